// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency word memory responder for the M stage with busy/ready handshake.
// Optional DMEM_POSTED_WRITE_EN adds a one-entry posted write buffer with read forwarding.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] WriteData_M,
  output logic [31:0] ReadData_M,
  output logic        MemReady_M,
  output logic        MemBusy_M,
  output logic        AddrErr_M
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT = 4'(LATENCY);
  state_t state;
  logic [3:0] cnt;
  logic op_wr, op_err;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [31:0] op_wd;
  logic [31:0] mem [2**DEPTH_LOG2];
  logic misal, req, accept, in_idle, do_access, a_wr, a_err, mem_we, post_now, unused;
  logic [DEPTH_LOG2-1:0] idx, a_idx, mem_widx;
  logic [31:0] a_wd, mem_wd, rd_word;
  assign misal = |Addr_M[1:0];
  assign req = MemRead_M | MemWrite_M;
  assign idx = Addr_M[DEPTH_LOG2+1:2];
  assign in_idle = state == IDLE;
  // with LATENCY=1 the access happens on the accept edge, so use the live request
  assign a_wr = in_idle ? MemWrite_M & ~MemRead_M : op_wr;
  assign a_err = in_idle ? misal | (MemRead_M & MemWrite_M) : op_err;
  assign a_idx = in_idle ? idx : op_idx;
  assign a_wd = in_idle ? WriteData_M : op_wd;
  assign do_access = in_idle ? accept && LAT == 4'd1 : state == WAIT && cnt <= 4'd1;
  assign unused = ^{Addr_M[31:DEPTH_LOG2+2], a_wd, op_wr};
`ifdef DMEM_POSTED_WRITE_EN
  logic buf_v, commit;
  logic [3:0] buf_cnt;
  logic [DEPTH_LOG2-1:0] buf_idx;
  logic [31:0] buf_d;
  assign post_now = RST & in_idle & MemWrite_M & ~MemRead_M & (misal | ~buf_v);
  assign accept = in_idle & MemRead_M;
  assign commit = buf_v && buf_cnt <= 4'd1;
  assign mem_we = commit;
  assign mem_widx = buf_idx;
  assign mem_wd = buf_d;
  assign rd_word = (buf_v && buf_idx == a_idx) ? buf_d : mem[a_idx];
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      buf_v <= 1'b0;
      buf_cnt <= '0;
      buf_idx <= '0;
      buf_d <= '0;
    end else if (post_now && !misal) begin
      buf_v <= 1'b1;
      buf_cnt <= LAT;
      buf_idx <= idx;
      buf_d <= WriteData_M;
    end else if (commit) begin
      buf_v <= 1'b0;
      buf_cnt <= '0;
    end else if (buf_v)
      buf_cnt <= buf_cnt - 4'd1;
`else
  assign post_now = 1'b0;
  assign accept = in_idle & req;
  assign mem_we = do_access & a_wr & ~a_err & RST;
  assign mem_widx = a_idx;
  assign mem_wd = a_wd;
  assign rd_word = mem[a_idx];
`endif
  assign MemBusy_M = RST & ((in_idle & req & ~post_now) | state == WAIT);
  assign MemReady_M = state == RESP | post_now;
  assign AddrErr_M = (state == RESP & op_err) | (post_now & misal);
  always_ff @(posedge CLK)
    if (mem_we) mem[mem_widx] <= mem_wd;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      op_wr <= 1'b0;
      op_err <= 1'b0;
      op_idx <= '0;
      op_wd <= '0;
      ReadData_M <= '0;
    end else begin
      if (do_access && !a_wr) ReadData_M <= a_err ? '0 : rd_word;
      case (state)
        IDLE: if (accept) begin
          op_wr <= a_wr;
          op_err <= a_err;
          op_idx <= idx;
          op_wd <= WriteData_M;
          cnt <= LAT - 4'd1;
          state <= (LAT == 4'd1) ? RESP : WAIT;
        end
        WAIT: if (cnt <= 4'd1) begin
          cnt <= '0;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder (default LATENCY=2, DEPTH_LOG2=10).
module tb_dmem_responder;
  localparam int LAT = 2;
`ifdef DMEM_POSTED_WRITE_EN
  localparam int WLAT = 0;
`else
  localparam int WLAT = LAT;
`endif
  logic CLK = 0, RST = 0, MemRead_M = 0, MemWrite_M = 0;
  logic [31:0] Addr_M = 0, WriteData_M = 0, ReadData_M;
  logic MemReady_M, MemBusy_M, AddrErr_M;
  typedef struct packed {logic err; logic rd; logic [31:0] d;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0;
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .Addr_M(Addr_M), .WriteData_M(WriteData_M), .ReadData_M(ReadData_M),
    .MemReady_M(MemReady_M), .MemBusy_M(MemBusy_M), .AddrErr_M(AddrErr_M)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  // monitor: pops the expected response whenever the DUT signals completion
  always @(negedge CLK)
    if (RST && MemReady_M) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready got 1 want 0");
      end else begin
        me = q.pop_front();
        chk("addr_err", {31'b0, AddrErr_M}, {31'b0, me.err});
        if (me.rd) chk("read_data", ReadData_M, me.d);
      end
    end
  // called #1 after a rising edge; leaves the bench #1 after the completion edge
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic err, input logic chk_d, input logic [31:0] d, input int lat);
    int n;
    q.push_back('{err: err, rd: chk_d, d: d});
    MemRead_M = rd;
    MemWrite_M = wr;
    Addr_M = a;
    WriteData_M = wd;
    n = 0;
    forever begin
      @(negedge CLK);
      if (MemReady_M || n > 20) break;
      chk("busy", {31'b0, MemBusy_M}, 32'd1);
      n++;
    end
    chk("latency", n, lat);
    chk("busy_at_ready", {31'b0, MemBusy_M}, 32'd0);
    @(posedge CLK);
    #1;
    MemRead_M = 0;
    MemWrite_M = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    MemRead_M = 1;
    #12;
    chk("rst_busy", {31'b0, MemBusy_M}, 32'd0);
    chk("rst_ready", {31'b0, MemReady_M}, 32'd0);
    chk("rst_err", {31'b0, AddrErr_M}, 32'd0);
    chk("rst_rdata", ReadData_M, 32'd0);
    MemRead_M = 0;
    @(negedge CLK);
    RST = 1;
    @(posedge CLK);
    #1;
    xfer(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, WLAT);
    xfer(1, 0, 32'h40, 0, 0, 1, 32'hDEADBEEF, LAT);
    xfer(1, 0, 32'h42, 0, 1, 1, 32'h0, LAT);
    xfer(1, 0, 32'h40, 0, 0, 1, 32'hDEADBEEF, LAT);
    xfer(0, 1, 32'h1000, 32'h11111111, 0, 0, 0, WLAT);
    xfer(1, 0, 32'h0, 0, 0, 1, 32'h11111111, LAT);
    xfer(0, 1, 32'h10, 32'h12345678, 0, 0, 0, WLAT);
    xfer(1, 1, 32'h10, 32'hFFFFFFFF, 1, 0, 0, LAT);
    xfer(1, 0, 32'h10, 0, 0, 1, 32'h12345678, LAT);
    xfer(0, 1, 32'hFFFFF004, 32'hCAFEF00D, 0, 0, 0, WLAT);
    xfer(1, 0, 32'h4, 0, 0, 1, 32'hCAFEF00D, LAT);
    xfer(0, 1, 32'h21, 32'h9, 1, 0, 0, WLAT);
    xfer(0, 1, 32'h20, 32'h77, 0, 0, 0, WLAT);
    xfer(1, 0, 32'h20, 0, 0, 1, 32'h77, LAT);
`ifdef DMEM_POSTED_WRITE_EN
    xfer(0, 1, 32'h80, 32'hA5A5A5A5, 0, 0, 0, 0);
    xfer(1, 0, 32'h80, 0, 0, 1, 32'hA5A5A5A5, LAT);
    xfer(0, 1, 32'h84, 32'h1, 0, 0, 0, 0);
    xfer(0, 1, 32'h88, 32'h2, 0, 0, 0, LAT);
    xfer(1, 0, 32'h84, 0, 0, 1, 32'h1, LAT);
    xfer(1, 0, 32'h88, 0, 0, 1, 32'h2, LAT);
`else
    MemWrite_M = 1;
    Addr_M = 32'h20;
    WriteData_M = 32'h5;
    @(negedge CLK);
    chk("abort_busy_idle", {31'b0, MemBusy_M}, 32'd1);
    @(negedge CLK);
    chk("abort_busy_wait", {31'b0, MemBusy_M}, 32'd1);
    RST = 0;
    #1;
    chk("abort_busy", {31'b0, MemBusy_M}, 32'd0);
    chk("abort_ready", {31'b0, MemReady_M}, 32'd0);
    chk("abort_err", {31'b0, AddrErr_M}, 32'd0);
    chk("abort_rdata", ReadData_M, 32'd0);
    MemWrite_M = 0;
    @(negedge CLK);
    RST = 1;
    @(posedge CLK);
    #1;
    xfer(1, 0, 32'h20, 0, 0, 1, 32'h77, LAT);
`endif
    repeat (3) @(posedge CLK);
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
